// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared types and widths for the pulse sequencer
package pulse_pkg;

    localparam int SEG_W_DEF     = 16;
    localparam int PER_SHIFT_DEF = 14;
    localparam int PARAM_W       = 32;
    localparam int PER_W         = 8;
    localparam int PBL_W         = 8;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_P1,
        ST_GAP,
        ST_P2,
        ST_BLANK
    } seq_state_t;

    // Natural successor of a segment, ignoring whether that successor is empty.
    function automatic seq_state_t seq_succ(input seq_state_t s, input logic cp);
        case (s)
            ST_P1:    return cp ? ST_GAP : ST_BLANK;
            ST_GAP:   return ST_P2;
            ST_P2:    return ST_BLANK;
            default:  return ST_WAIT;
        endcase
    endfunction

endpackage

// File: rtl/seg_timer.sv
// rtl/seg_timer.sv - loadable down-counter timing one FSM segment
module seg_timer #(
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEG_W-1:0] value,
    output logic             expire,
    output logic             zero
);

    logic [SEG_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - SEG_W'(1);
        end
    end

    // expire marks the last cycle of a segment; zero marks an idle/empty timer
    assign expire = (cnt == SEG_W'(1));
    assign zero   = (cnt == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - period-locked RF pulse / blanking / sync generator
module pulse_sequencer
    import pulse_pkg::*;
#(
    parameter int PER_SHIFT = PER_SHIFT_DEF,
    parameter int SEG_W     = SEG_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PARAM_W-1:0] per,
    input  logic [PARAM_W-1:0] p1wid,
    input  logic [PARAM_W-1:0] del,
    input  logic [PARAM_W-1:0] p2wid,
    input  logic               pu,
    input  logic               cp,
    input  logic [PBL_W-1:0]   p_bl,
    input  logic               bl,
    output logic               sync_out,
    output logic               pulse_out,
    output logic               block_out,
    output logic               active
);

    localparam int PCNT_W = PER_W + PER_SHIFT;

    logic [PCNT_W-1:0] pcnt;
    logic [PCNT_W-1:0] pcnt_last;
    logic              pcnt_zero;

    logic [PER_W-1:0]  per_sh, per_d, per_eff;
    logic [SEG_W-1:0]  p1_sh, p1_d;
    logic [SEG_W-1:0]  del_sh, del_d;
    logic [SEG_W-1:0]  p2_sh, p2_d;
    logic [PBL_W-1:0]  pbl_sh, pbl_d;
    logic              pu_sh, pu_d, cp_sh, cp_d, bl_sh, bl_d;

    seq_state_t        state, state_nxt;
    logic              tmr_load, tmr_expire, tmr_zero, seg_done;
    logic [SEG_W-1:0]  tmr_value;

    logic              unused_bits;
    assign unused_bits = ^{per[PARAM_W-1:PER_W], p1wid[PARAM_W-1:SEG_W],
                           del[PARAM_W-1:SEG_W], p2wid[PARAM_W-1:SEG_W]};

    function automatic logic [SEG_W-1:0] seg_len(
        input seq_state_t s, input logic [SEG_W-1:0] l1, input logic [SEG_W-1:0] ld,
        input logic [SEG_W-1:0] l2, input logic [PBL_W-1:0] lb);
        case (s)
            ST_P1:    return l1;
            ST_GAP:   return ld;
            ST_P2:    return l2;
            ST_BLANK: return SEG_W'(lb);
            default:  return '0;
        endcase
    endfunction

    // Walk past zero-length segments so an empty state never costs a cycle.
    function automatic seq_state_t skip_empty(
        input seq_state_t s, input logic c, input logic [SEG_W-1:0] l1,
        input logic [SEG_W-1:0] ld, input logic [SEG_W-1:0] l2, input logic [PBL_W-1:0] lb);
        seq_state_t r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (r != ST_WAIT && seg_len(r, l1, ld, l2, lb) == '0) begin
                r = seq_succ(r, c);
            end
        end
        return r;
    endfunction

    assign pcnt_zero = (pcnt == '0);

    // Shadow values as they will be after this edge; outputs are computed from these
    // so that sync, pulse and block all rise on the period-start edge.
    assign per_d   = pcnt_zero ? per[PER_W-1:0]   : per_sh;
    assign p1_d    = pcnt_zero ? p1wid[SEG_W-1:0] : p1_sh;
    assign del_d   = pcnt_zero ? del[SEG_W-1:0]   : del_sh;
    assign p2_d    = pcnt_zero ? p2wid[SEG_W-1:0] : p2_sh;
    assign pbl_d   = pcnt_zero ? p_bl             : pbl_sh;
    assign pu_d    = pcnt_zero ? pu               : pu_sh;
    assign cp_d    = pcnt_zero ? cp               : cp_sh;
    assign bl_d    = pcnt_zero ? bl               : bl_sh;

    assign per_eff   = (per_d == '0) ? PER_W'(1) : per_d;
    assign pcnt_last = (PCNT_W'(per_eff) << PER_SHIFT) - PCNT_W'(1);
    assign seg_done  = tmr_expire | tmr_zero;

    always_comb begin
        state_nxt = state;
        if (pcnt_zero) begin
            state_nxt = skip_empty(ST_P1, cp_d, p1_d, del_d, p2_d, pbl_d);
        end else if (state != ST_WAIT && seg_done) begin
            state_nxt = skip_empty(seq_succ(state, cp_d), cp_d, p1_d, del_d, p2_d, pbl_d);
        end
        tmr_load  = pcnt_zero || (state_nxt != state);
        tmr_value = seg_len(state_nxt, p1_d, del_d, p2_d, pbl_d);
    end

    seg_timer #(.SEG_W(SEG_W)) u_seg_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire),
        .zero   (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt   <= '0;
            state  <= ST_WAIT;
            per_sh <= '0;
            p1_sh  <= '0;
            del_sh <= '0;
            p2_sh  <= '0;
            pbl_sh <= '0;
            pu_sh  <= 1'b0;
            cp_sh  <= 1'b0;
            bl_sh  <= 1'b0;
        end else begin
            pcnt   <= (pcnt == pcnt_last) ? '0 : pcnt + PCNT_W'(1);
            state  <= state_nxt;
            per_sh <= per_d;
            p1_sh  <= p1_d;
            del_sh <= del_d;
            p2_sh  <= p2_d;
            pbl_sh <= pbl_d;
            pu_sh  <= pu_d;
            cp_sh  <= cp_d;
            bl_sh  <= bl_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_out  <= 1'b0;
            pulse_out <= 1'b0;
            block_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            sync_out  <= pcnt_zero;
            pulse_out <= pu_d && (state_nxt == ST_P1 || state_nxt == ST_P2);
            block_out <= bl_d && pu_d && (state_nxt != ST_WAIT);
            active    <= (state_nxt != ST_WAIT);
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - scoreboard bench for pulse_sequencer
module tb_pulse_sequencer;

    localparam int PS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] per = 32'd0, p1wid = 32'd0, del = 32'd0, p2wid = 32'd0;
    logic        pu = 1'b0, cp = 1'b0, bl = 1'b0;
    logic [7:0]  p_bl = 8'd0;
    logic        sync_out, pulse_out, block_out, active;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  exp_q[$];

    pulse_sequencer #(.PER_SHIFT(PS), .SEG_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .per       (per),
        .p1wid     (p1wid),
        .del       (del),
        .p2wid     (p2wid),
        .pu        (pu),
        .cp        (cp),
        .p_bl      (p_bl),
        .bl        (bl),
        .sync_out  (sync_out),
        .pulse_out (pulse_out),
        .block_out (block_out),
        .active    (active)
    );

    always #5 clk = ~clk;

    function automatic int period_len();
        int p;
        p = int'(per[7:0]);
        return (p == 0 ? 1 : p) << PS;
    endfunction

    // Expected {sync, pulse, block, active} for every cycle of one period,
    // derived from segment boundaries measured from the sync edge.
    function automatic void push_period();
        int p1, d, p2, pb, seq_end, act_end;
        logic s, pl, b, a;
        p1 = int'(p1wid[15:0]);
        d  = int'(del[15:0]);
        p2 = int'(p2wid[15:0]);
        pb = int'(p_bl);
        seq_end = cp ? (p1 + d + p2) : p1;
        act_end = seq_end + pb;
        for (int i = 0; i < period_len(); i++) begin
            s  = (i == 0);
            pl = pu && ((i < p1) || (cp && i >= p1 + d && i < seq_end));
            a  = (i < act_end);
            b  = bl && pu && a;
            exp_q.push_back({s, pl, b, a});
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_params(input int pr, input int a, input int d, input int b,
                              input int pbl_v, input logic pu_v, input logic cp_v, input logic bl_v);
        per = pr; p1wid = a; del = d; p2wid = b;
        p_bl = pbl_v[7:0]; pu = pu_v; cp = cp_v; bl = bl_v;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst = 1'b1;
        set_params(2, 5, 0, 0, 3, 1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        got = {sync_out, pulse_out, block_out, active};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 0000", got);
        end
    endtask

    task automatic test_single_pulse();
        logic [3:0] got, e;
        set_params(2, 5, 0, 0, 3, 1'b1, 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_period();
            for (int i = 0; i < period_len(); i++) begin
                @(negedge clk);
                got = {sync_out, pulse_out, block_out, active};
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL single_pulse p%0d c%0d: got %b expected %b", k, i, got, e);
                end
            end
        end
    endtask

    task automatic test_hahn_echo();
        logic [3:0] got, e;
        set_params(4, 3, 10, 6, 4, 1'b1, 1'b1, 1'b1);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push_period();
            for (int i = 0; i < period_len(); i++) begin
                @(negedge clk);
                got = {sync_out, pulse_out, block_out, active};
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL hahn_echo p%0d c%0d: got %b expected %b", k, i, got, e);
                end
            end
        end
    endtask

    task automatic test_zero_and_disable();
        int   t_per[5] = '{2, 2, 0, 2, 2};
        int   t_p1[5]  = '{0, 4, 3, 3, 3};
        int   t_del[5] = '{10, 0, 4, 4, 4};
        int   t_p2[5]  = '{6, 5, 2, 5, 5};
        logic t_pu[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic t_bl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] got, e;
        for (int c = 0; c < 5; c++) begin
            set_params(t_per[c], t_p1[c], t_del[c], t_p2[c], 3, t_pu[c], 1'b1, t_bl[c]);
            do_reset();
            for (int k = 0; k < 2; k++) begin
                push_period();
                for (int i = 0; i < period_len(); i++) begin
                    @(negedge clk);
                    got = {sync_out, pulse_out, block_out, active};
                    e = exp_q.pop_front();
                    n_checks++;
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL zero_disable case%0d p%0d c%0d: got %b expected %b", c, k, i, got, e);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_update();
        logic [3:0] got, e;
        set_params(4, 5, 10, 6, 2, 1'b1, 1'b1, 1'b1);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push_period();
            for (int i = 0; i < period_len(); i++) begin
                @(negedge clk);
                if (k == 0 && i == 8) p1wid = 32'd9;
                got = {sync_out, pulse_out, block_out, active};
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL mid_update p%0d c%0d: got %b expected %b", k, i, got, e);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [3:0] got, e;
        set_params(1, 20, 0, 0, 3, 1'b1, 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_period();
            for (int i = 0; i < period_len(); i++) begin
                @(negedge clk);
                got = {sync_out, pulse_out, block_out, active};
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL overrun p%0d c%0d: got %b expected %b", k, i, got, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_p2();
        logic [3:0] got, e;
        set_params(4, 3, 10, 6, 2, 1'b1, 1'b1, 1'b1);
        do_reset();
        push_period();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            got = {sync_out, pulse_out, block_out, active};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL pre_reset c%0d: got %b expected %b", i, got, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        got = {sync_out, pulse_out, block_out, active};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 0000", got);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_period();
        for (int i = 0; i < period_len(); i++) begin
            @(negedge clk);
            got = {sync_out, pulse_out, block_out, active};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL post_reset c%0d: got %b expected %b", i, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_hahn_echo();
        test_zero_and_disable();
        test_mid_update();
        test_overrun();
        test_reset_mid_p2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
